// File: rtl/counter_pkg.sv
// Shared state encoding and width helper for the counter_r1 family.
package counter_pkg;

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int STATE_W = log2_ceil(3);

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/counter_r1_pipe.sv
// Fixed-depth register delay line with synchronous reset to RST_VAL.
// DEPTH=0 degenerates to a plain wire.
module counter_r1_pipe #(
  parameter int           W       = 1,
  parameter int           DEPTH   = 0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_regs
      logic [W-1:0] stage_q [DEPTH];
      logic [W-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/counter_r1.sv
// Up/down wrap or one-shot counter with load clamp and DELAY-stage output pipe.
// Optional sticky wrap_flag output when COUNTER_R1_WRAP_FLAG_EN is defined.
module counter_r1
  import counter_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int MIN_COUNT = 0,
  parameter int MAX_COUNT = 32,
  parameter int STEP      = 1,
  parameter int ONE_SHOT  = 0,
  parameter int DELAY     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
`ifdef COUNTER_R1_WRAP_FLAG_EN
  ,
  output logic             wrap_flag
`endif
);

  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_COUNT);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN_COUNT);
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  // One extra bit on every compare so bound arithmetic never aliases.
  logic [WIDTH:0] cnt_x, din_x, sum_x, diff_x;
  assign cnt_x  = {1'b0, count_q};
  assign din_x  = {1'b0, data_in};
  assign sum_x  = cnt_x + STEP_X;
  assign diff_x = cnt_x - STEP_X;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      state_d = IDLE;
      if (din_x < MIN_X)      count_d = MIN_W;
      else if (din_x > MAX_X) count_d = MAX_W;
      else                    count_d = data_in;
    end else begin
      case (state_q)
        IDLE: if (run) state_d = RUN;
        RUN: begin
          if (!run) begin
            state_d = IDLE;
          end else if (up_dn) begin
            if (cnt_x > MAX_X - STEP_X) begin
              tc_d = 1'b1;
              if (ONE_SHOT != 0) begin
                count_d = MAX_W;
                state_d = DONE;
              end else begin
                count_d = MIN_W;
              end
            end else begin
              count_d = sum_x[WIDTH-1:0];
            end
          end else begin
            if (cnt_x < MIN_X + STEP_X) begin
              tc_d = 1'b1;
              if (ONE_SHOT != 0) begin
                count_d = MIN_W;
                state_d = DONE;
              end else begin
                count_d = MAX_W;
              end
            end else begin
              count_d = diff_x[WIDTH-1:0];
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= MIN_W;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign busy = (state_q == RUN);

  logic [WIDTH:0] pipe_q;

  counter_r1_pipe #(
    .W       (WIDTH + 1),
    .DEPTH   (DELAY),
    .RST_VAL ({1'b0, MIN_W})
  ) u_pipe (
    .clk (clk),
    .rst (rst),
    .d   ({tc_q, count_q}),
    .q   (pipe_q)
  );

  assign {tc, count} = pipe_q;

`ifdef COUNTER_R1_WRAP_FLAG_EN
  logic wrap_flag_q, wrap_flag_d;

  // Rises on the same edge that registers the wrap/terminal event.
  always_comb begin
    wrap_flag_d = wrap_flag_q | tc_d;
    if (load) wrap_flag_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) wrap_flag_q <= 1'b0;
    else     wrap_flag_q <= wrap_flag_d;
  end

  assign wrap_flag = wrap_flag_q;
`endif

endmodule

// File: tb/tb_counter_r1.sv
// Three counter_r1 configurations on shared stimulus, checked by directed
// scenarios and a randomized run against an integer reference model.
module tb_counter_r1;

  localparam int N = 3;
  localparam int P_MIN  [N] = '{0, 2, 0};
  localparam int P_MAX  [N] = '{9, 9, 5};
  localparam int P_STEP [N] = '{1, 3, 1};
  localparam int P_OS   [N] = '{0, 0, 1};
  localparam int P_DLY  [N] = '{0, 2, 1};

  logic       clk;
  logic       rst, load, run, up_dn;
  logic [5:0] data_in;
  logic [5:0] cnt_o  [N];
  logic       tc_o   [N];
  logic       busy_o [N];
`ifdef COUNTER_R1_WRAP_FLAG_EN
  logic       wf_o   [N];
`endif

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    counter_r1 #(
      .WIDTH     (6),
      .MIN_COUNT (P_MIN[g]),
      .MAX_COUNT (P_MAX[g]),
      .STEP      (P_STEP[g]),
      .ONE_SHOT  (P_OS[g]),
      .DELAY     (P_DLY[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .run       (run),
      .up_dn     (up_dn),
      .data_in   (data_in),
      .count     (cnt_o[g]),
      .tc        (tc_o[g]),
      .busy      (busy_o[g])
`ifdef COUNTER_R1_WRAP_FLAG_EN
      ,
      .wrap_flag (wf_o[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 = stopped, 1 = counting, 2 = finished.
  int m_cnt [N];
  int m_mode[N];
  int m_wf  [N];
  int hc[N][4];
  int ht[N][4];

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      int c, t, md;
      c = m_cnt[i]; t = 0; md = m_mode[i];
      if (rst) begin
        c = P_MIN[i]; md = 0; m_wf[i] = 0;
        for (int k = 0; k < 4; k++) begin hc[i][k] = P_MIN[i]; ht[i][k] = 0; end
      end else begin
        if (load) begin
          c = int'(data_in);
          if (c < P_MIN[i]) c = P_MIN[i];
          if (c > P_MAX[i]) c = P_MAX[i];
          md = 0; m_wf[i] = 0;
        end else if (md == 0) begin
          if (run) md = 1;
        end else if (md == 1) begin
          if (!run) md = 0;
          else if (up_dn) begin
            if (c + P_STEP[i] > P_MAX[i]) begin
              t = 1;
              if (P_OS[i] != 0) begin c = P_MAX[i]; md = 2; end
              else c = P_MIN[i];
            end else c = c + P_STEP[i];
          end else begin
            if (c - P_STEP[i] < P_MIN[i]) begin
              t = 1;
              if (P_OS[i] != 0) begin c = P_MIN[i]; md = 2; end
              else c = P_MAX[i];
            end else c = c - P_STEP[i];
          end
        end
        if (t != 0) m_wf[i] = 1;
        for (int k = 3; k > 0; k--) begin hc[i][k] = hc[i][k-1]; ht[i][k] = ht[i][k-1]; end
        hc[i][0] = c; ht[i][0] = t;
      end
      m_cnt[i] = c; m_mode[i] = md;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic r, input logic l, input logic rn,
                        input logic u, input int d);
    rst = r; load = l; run = rn; up_dn = u; data_in = 6'(d);
  endtask

  task automatic test_reset();
    set_in(1, 1, 1, 1, 5);
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cnt_o[i] !== 6'(P_MIN[i]) || tc_o[i] !== 1'b0 || busy_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: count=%0d tc=%b busy=%b, need count=%0d tc=0 busy=0",
                 i, cnt_o[i], tc_o[i], busy_o[i], P_MIN[i]);
      end
    end
  endtask

  task automatic test_up_wrap();
    set_in(1, 0, 0, 1, 0); tick();
    set_in(0, 0, 1, 1, 0); tick();
    checks++;
    if (cnt_o[0] !== 6'd0 || busy_o[0] !== 1'b1) begin
      errors++; $display("FAIL up_start: count=%0d busy=%b, need 0 1", cnt_o[0], busy_o[0]);
    end
    for (int k = 1; k <= 11; k++) begin
      int ec, et;
      tick();
      ec = k % 10; et = (k == 10) ? 1 : 0;
      checks++;
      if (int'(cnt_o[0]) != ec || int'(tc_o[0]) != et) begin
        errors++;
        $display("FAIL up_wrap step %0d: count=%0d tc=%b, need %0d %0d", k, cnt_o[0], tc_o[0], ec, et);
      end
    end
  endtask

  task automatic test_down_step3();
    int exp_c [6] = '{9, 9, 6, 3, 9, 6};
    int exp_t [6] = '{0, 0, 0, 0, 1, 0};
    set_in(0, 1, 0, 0, 9); tick();
    set_in(0, 0, 1, 0, 0); tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (int'(cnt_o[1]) != exp_c[k] || int'(tc_o[1]) != exp_t[k]) begin
        errors++;
        $display("FAIL down_step3 %0d: count=%0d tc=%b, need %0d %0d", k, cnt_o[1], tc_o[1], exp_c[k], exp_t[k]);
      end
    end
  endtask

  task automatic test_one_shot();
    // Columns: count (1-cycle delayed), tc, busy after each edge from the first run edge.
    int exp_c [6] = '{3, 3, 4, 5, 5, 5};
    int exp_t [6] = '{0, 0, 0, 0, 1, 0};
    int exp_b [6] = '{1, 1, 1, 0, 0, 0};
    set_in(0, 1, 0, 1, 3); tick();
    set_in(0, 0, 1, 1, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (int'(cnt_o[2]) != exp_c[k] || int'(tc_o[2]) != exp_t[k] || int'(busy_o[2]) != exp_b[k]) begin
        errors++;
        $display("FAIL one_shot %0d: count=%0d tc=%b busy=%b, need %0d %0d %0d",
                 k, cnt_o[2], tc_o[2], busy_o[2], exp_c[k], exp_t[k], exp_b[k]);
      end
    end
    set_in(0, 1, 1, 1, 0); tick();
    checks++;
    if (busy_o[2] !== 1'b0) begin
      errors++; $display("FAIL one_shot_load busy=%b, need 0", busy_o[2]);
    end
    set_in(0, 0, 1, 1, 0); tick();
    checks++;
    if (cnt_o[2] !== 6'd0 || busy_o[2] !== 1'b1) begin
      errors++; $display("FAIL one_shot_rerun: count=%0d busy=%b, need 0 1", cnt_o[2], busy_o[2]);
    end
  endtask

  task automatic test_load_priority();
    set_in(0, 1, 1, 1, 12); tick();
    checks++;
    if (cnt_o[0] !== 6'd9 || busy_o[0] !== 1'b0 || tc_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp: count=%0d busy=%b tc=%b, need 9 0 0", cnt_o[0], busy_o[0], tc_o[0]);
    end
    set_in(0, 0, 1, 1, 0); tick();
    checks++;
    if (cnt_o[0] !== 6'd9 || busy_o[0] !== 1'b1) begin
      errors++; $display("FAIL load_then_run: count=%0d busy=%b, need 9 1", cnt_o[0], busy_o[0]);
    end
    tick();
    checks++;
    if (cnt_o[0] !== 6'd0 || tc_o[0] !== 1'b1) begin
      errors++; $display("FAIL load_then_wrap: count=%0d tc=%b, need 0 1", cnt_o[0], tc_o[0]);
    end
  endtask

  task automatic test_rst_mid_run();
    set_in(0, 1, 0, 1, 7); tick();
    set_in(0, 0, 1, 1, 0); tick();
    set_in(1, 1, 1, 1, 8); tick();
    checks++;
    if (cnt_o[1] !== 6'd2 || tc_o[1] !== 1'b0 || busy_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_run: count=%0d tc=%b busy=%b, need 2 0 0", cnt_o[1], tc_o[1], busy_o[1]);
    end
    set_in(0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (cnt_o[1] !== 6'd2 || tc_o[1] !== 1'b0) begin
        errors++;
        $display("FAIL rst_settle %0d: count=%0d tc=%b, need 2 0", k, cnt_o[1], tc_o[1]);
      end
    end
  endtask

`ifdef COUNTER_R1_WRAP_FLAG_EN
  task automatic test_wrap_flag();
    set_in(1, 0, 0, 1, 0); tick();
    set_in(0, 0, 1, 1, 0);
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (wf_o[0] !== 1'b0) begin
      errors++; $display("FAIL wrap_flag_pre=%b, need 0", wf_o[0]);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wf_o[0] !== 1'b1) begin
        errors++; $display("FAIL wrap_flag_sticky %0d=%b, need 1", k, wf_o[0]);
      end
      tick();
    end
    set_in(0, 1, 0, 1, 4); tick();
    checks++;
    if (wf_o[0] !== 1'b0) begin
      errors++; $display("FAIL wrap_flag_load=%b, need 0", wf_o[0]);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(99) < 3), ($urandom_range(99) < 8), ($urandom_range(99) < 85),
             1'($urandom), int'($urandom_range(63)));
      tick();
      for (int i = 0; i < N; i++) begin
        int ec, et, eb;
        ec = hc[i][P_DLY[i]]; et = ht[i][P_DLY[i]]; eb = (m_mode[i] == 1) ? 1 : 0;
        checks++;
        if (int'(cnt_o[i]) != ec || int'(tc_o[i]) != et || int'(busy_o[i]) != eb) begin
          errors++;
          $display("FAIL random[%0d] cyc %0d: count=%0d tc=%b busy=%b, need %0d %0d %0d",
                   i, n, cnt_o[i], tc_o[i], busy_o[i], ec, et, eb);
        end
`ifdef COUNTER_R1_WRAP_FLAG_EN
        checks++;
        if (int'(wf_o[i]) != m_wf[i]) begin
          errors++;
          $display("FAIL random_wf[%0d] cyc %0d: wrap_flag=%b, need %0d", i, n, wf_o[i], m_wf[i]);
        end
`endif
      end
    end
  endtask

  initial begin
    set_in(1, 0, 0, 1, 0);
    test_reset();
    test_up_wrap();
    test_down_step3();
    test_one_shot();
    test_load_priority();
    test_rst_mid_run();
`ifdef COUNTER_R1_WRAP_FLAG_EN
    test_wrap_flag();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_r1.md
COUNTER_R1 -- requirements
Module: counter_r1

Interface
REQ-001 SHALL have parameter WIDTH, default 6, bit width of count and data_in.
REQ-002 SHALL have parameter MIN_COUNT, default 0, lower wrap bound.
REQ-003 SHALL have parameter MAX_COUNT, default 32, upper wrap bound; MIN_COUNT < MAX_COUNT < 2**WIDTH.
REQ-004 SHALL have parameter STEP, default 1, increment magnitude; 1 <= STEP <= MAX_COUNT-MIN_COUNT.
REQ-005 SHALL have parameter ONE_SHOT, default 0, where 0 means free-running wrap and 1 means stop at the terminal value.
REQ-006 SHALL have parameter DELAY, default 0, number of output register stages on count and tc.
REQ-007 SHALL have port clk, input, 1 bit, clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, reset, synchronous, active-high.
REQ-009 SHALL have port load, input, 1 bit, load data_in into the counter.
REQ-010 SHALL have port run, input, 1 bit, level-sensitive count enable.
REQ-011 SHALL have port up_dn, input, 1 bit, where 1 counts up and 0 counts down.
REQ-012 SHALL have port data_in, input, WIDTH bits, load value.
REQ-013 SHALL have port count, output, WIDTH bits, counter value after DELAY stages.
REQ-014 SHALL have port tc, output, 1 bit, one-cycle terminal-count pulse after DELAY stages.
REQ-015 SHALL have port busy, output, 1 bit, high while in RUN; undelayed.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE.
REQ-017 SHALL apply priority per cycle: rst, then load, then stepping.
REQ-018 SHALL, on load in any state, set count_q to data_in clamped to [MIN_COUNT, MAX_COUNT], go to IDLE and not step that cycle.
REQ-019 SHALL transition IDLE to RUN when run=1 and load=0; the first step occurs on the following edge.
REQ-020 SHALL transition RUN to IDLE when run=0, holding count_q.
REQ-021 SHALL, in RUN with up_dn=1: if count_q > MAX_COUNT-STEP, set count_q to MIN_COUNT with tc_q=1; otherwise add STEP.
REQ-022 SHALL, in RUN with up_dn=0: if count_q < MIN_COUNT+STEP, set count_q to MAX_COUNT with tc_q=1; otherwise subtract STEP.
REQ-023 SHALL, when ONE_SHOT=1, saturate at the terminal bound instead of wrapping (MAX_COUNT up, MIN_COUNT down), assert tc_q for one cycle, and enter DONE.
REQ-024 SHALL, in DONE, hold count_q and ignore run until load or rst.
REQ-025 SHALL evaluate all compares at WIDTH+1 bits with no overflow aliasing.
REQ-026 SHALL hold tc_q low in every cycle without a wrap or terminal event.
REQ-027 SHALL give count and tc a latency of exactly DELAY cycles from count_q/tc_q; DELAY=0 gives a direct wire.
REQ-028 SHALL take the up_dn sample in the stepping cycle; a direction change mid-run takes effect on the next step.

Reset
REQ-029 SHALL, on rst, set state to IDLE, count_q to MIN_COUNT, tc_q to 0, and clear all delay stages to MIN_COUNT and 0.
REQ-030 SHALL drive busy=0 on the edge after rst; count=MIN_COUNT and tc=0 hold immediately for every DELAY.
REQ-031 SHALL let rst mid-RUN or in DONE override load and run in the same cycle.

Configuration
REQ-032 SHALL recognise macro COUNTER_R1_WRAP_FLAG_EN.
REQ-033 SHALL, when the macro is defined, add output wrap_flag (1 bit, sticky): set on any tc_q, cleared by rst or load, undelayed.
REQ-034 SHALL, when the macro is undefined, omit the wrap_flag port and its logic, with all other behaviour identical.

Structure
REQ-035 SHALL place state encoding constants (IDLE, RUN, DONE) and the log2 width helper in shared package counter_pkg.
REQ-036 SHALL implement the output delay line as sub-module counter_r1_pipe (WIDTH+1 bits, DEPTH=DELAY, synchronous reset value parameter).

Verification
REQ-037 SHALL cover: MIN=0, MAX=9, STEP=1, up_dn=1, run held -> count 0..9, 0; tc high exactly when count=0 after 9.
REQ-038 SHALL cover: MIN=2, MAX=9, STEP=3, up_dn=0, load 9 then run -> 9, 6, 3, 9; tc on the 3->9 wrap.
REQ-039 SHALL cover: ONE_SHOT=1, MAX=5, load 3, run -> 4, 5, DONE; busy falls; count holds 5 with run high; load 0 returns to IDLE.
REQ-040 SHALL cover: load=1, run=1 same cycle with data_in=12 and MAX=9 -> count=9, state IDLE, no step, tc=0.
REQ-041 SHALL cover: DELAY=2, rst pulsed mid-RUN at count=7 -> count=MIN immediately, busy=0 next cycle, no spurious tc.
REQ-042 SHALL cover: COUNTER_R1_WRAP_FLAG_EN defined, wrap at 9->0 -> wrap_flag=1 sticky through further counting; load clears it.
